// File: rtl/window_3x3_sweeper_pkg.sv
// Shared definitions for the 3x3 window pipeline (line buffer, sweeper, MAC stage).
// Default geometry, derived widths, sweep FSM state type and a column clamp helper.
package window_3x3_sweeper_pkg;

    localparam int CNN_DATA_BITS = 8;
    localparam int CNN_H         = 24;
    localparam int CNN_W         = 24;
    localparam int CNN_K         = 6;

    localparam int PIX_W    = CNN_K * CNN_DATA_BITS;
    localparam int ROW_W    = CNN_W * PIX_W;
    localparam int WIN_W    = 9 * PIX_W;
    localparam int COL_BITS = $clog2(CNN_W);
    localparam int ROW_BITS = $clog2(CNN_H);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    // Keeps a pixel index inside the row so out-of-range columns never form an illegal select.
    function automatic int unsigned clamp_col(input int unsigned idx, input int unsigned width);
        return (idx > width - 1) ? width - 1 : idx;
    endfunction

endpackage

// File: rtl/window_3x3_sweeper_window_col_mux.sv
// Combinational 3x3 window extraction: picks columns col..col+2 from three stored rows.
// Tap t = r*3 + dx occupies window_o[t*PIX +: PIX]; channel order inside a pixel is preserved.
module window_col_mux
    import window_3x3_sweeper_pkg::*;
#(
    parameter int DATA_BITS = CNN_DATA_BITS,
    parameter int W         = CNN_W,
    parameter int K         = CNN_K,
    parameter int COL_BITS  = $clog2(CNN_W)
) (
    input  logic [W*K*DATA_BITS-1:0] row_0,
    input  logic [W*K*DATA_BITS-1:0] row_1,
    input  logic [W*K*DATA_BITS-1:0] row_2,
    input  logic [COL_BITS-1:0]      col,
    output logic [9*K*DATA_BITS-1:0] window_o
);

    localparam int PIX_SZ = K * DATA_BITS;

    int unsigned idx;

    always_comb begin
        window_o = '0;
        idx      = 0;
        for (int unsigned dx = 0; dx < 3; dx++) begin
            idx = clamp_col(32'(col) + dx, W);
            window_o[dx*PIX_SZ +: PIX_SZ]       = row_0[idx*PIX_SZ +: PIX_SZ];
            window_o[(3+dx)*PIX_SZ +: PIX_SZ]   = row_1[idx*PIX_SZ +: PIX_SZ];
            window_o[(6+dx)*PIX_SZ +: PIX_SZ]   = row_2[idx*PIX_SZ +: PIX_SZ];
        end
    end

endmodule

// File: rtl/window_3x3_sweeper.sv
// Sweeps a 3x3 window left to right across a captured row triplet, one window per handshake.
// Back-to-back triplets are accepted on the final-column handshake with no bubble.
module window_3x3_sweeper
    import window_3x3_sweeper_pkg::*;
#(
    parameter int DATA_BITS = CNN_DATA_BITS,
    parameter int H         = CNN_H,
    parameter int W         = CNN_W,
    parameter int K         = CNN_K
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [W*K*DATA_BITS-1:0] row_0,
    input  logic [W*K*DATA_BITS-1:0] row_1,
    input  logic [W*K*DATA_BITS-1:0] row_2,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [9*K*DATA_BITS-1:0] window_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [$clog2(W)-1:0]     col_o,
    output logic [$clog2(H)-1:0]     row_o,
    output logic                     last_col_o,
    output logic                     last_frame_o,
    output logic                     overflow_o
);

    localparam int ROW_SZ = W * K * DATA_BITS;
    localparam int CW     = $clog2(W);
    localparam int RW     = $clog2(H);
    localparam logic [CW-1:0] LAST_COL = CW'(W - 3);
    localparam logic [RW-1:0] LAST_ROW = RW'(H - 3);

    state_t            state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [ROW_SZ-1:0] row_0_q;
    logic [ROW_SZ-1:0] row_1_q;
    logic [ROW_SZ-1:0] row_2_q;
    logic              overflow_q;
    logic              at_last_col;
    logic              capture;

    assign valid_o      = (state == SWEEP);
    assign at_last_col  = (col == LAST_COL);
    // Final-column handshake frees the row registers in the same cycle, hence ready_i feeds ready_o.
    assign ready_o      = (state == IDLE) | (valid_o & at_last_col & ready_i);
    assign capture      = valid_i & ready_o;
    assign last_col_o   = valid_o & at_last_col;
    assign last_frame_o = last_col_o & (row == LAST_ROW);
    assign col_o        = col;
    assign row_o        = row;
    assign overflow_o   = overflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            overflow_q <= 1'b0;
            row_0_q    <= '0;
            row_1_q    <= '0;
            row_2_q    <= '0;
        end else begin
            if (valid_i && !ready_o) begin
                overflow_q <= 1'b1;
            end
            if (capture) begin
                row_0_q <= row_0;
                row_1_q <= row_1;
                row_2_q <= row_2;
            end
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        col   <= '0;
                        state <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (ready_i) begin
                        if (at_last_col) begin
                            row   <= (row == LAST_ROW) ? '0 : row + 1'b1;
                            col   <= '0;
                            state <= valid_i ? SWEEP : IDLE;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    window_col_mux #(
        .DATA_BITS (DATA_BITS),
        .W         (W),
        .K         (K),
        .COL_BITS  (CW)
    ) u_col_mux (
        .row_0    (row_0_q),
        .row_1    (row_1_q),
        .row_2    (row_2_q),
        .col      (col),
        .window_o (window_o)
    );

endmodule

// File: tb/tb_window_3x3_sweeper.sv
// Directed bench for window_3x3_sweeper: pixel value = base + x + 32*r + c.
module tb_window_3x3_sweeper;

    localparam int DB    = 8;
    localparam int H     = 24;
    localparam int W     = 24;
    localparam int K     = 6;
    localparam int PIX   = K * DB;
    localparam int ROW_W = W * PIX;
    localparam int WIN_W = 9 * PIX;
    localparam int CB    = $clog2(W);
    localparam int RB    = $clog2(H);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [ROW_W-1:0] row_0 = '0;
    logic [ROW_W-1:0] row_1 = '0;
    logic [ROW_W-1:0] row_2 = '0;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [WIN_W-1:0] window_o;
    logic             valid_o;
    logic             ready_i = 1'b1;
    logic [CB-1:0]    col_o;
    logic [RB-1:0]    row_o;
    logic             last_col_o;
    logic             last_frame_o;
    logic             overflow_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    window_3x3_sweeper #(
        .DATA_BITS (DB),
        .H         (H),
        .W         (W),
        .K         (K)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .row_0        (row_0),
        .row_1        (row_1),
        .row_2        (row_2),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .window_o     (window_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .col_o        (col_o),
        .row_o        (row_o),
        .last_col_o   (last_col_o),
        .last_frame_o (last_frame_o),
        .overflow_o   (overflow_o)
    );

    function automatic logic [ROW_W-1:0] make_row(input int r, input int base);
        logic [ROW_W-1:0] v;
        logic [7:0]       p;
        v = '0;
        for (int x = 0; x < W; x++)
            for (int c = 0; c < K; c++) begin
                p = 8'(base + x + 32 * r + c);
                v[(x*K+c)*DB +: DB] = p;
            end
        return v;
    endfunction

    function automatic logic [WIN_W-1:0] exp_win(input int base, input int col);
        logic [WIN_W-1:0] v;
        logic [7:0]       p;
        v = '0;
        for (int t = 0; t < 9; t++)
            for (int c = 0; c < K; c++) begin
                p = 8'(base + (col + t % 3) + 32 * (t / 3) + c);
                v[(t*K+c)*DB +: DB] = p;
            end
        return v;
    endfunction

    task automatic check(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int base);
        row_0 = make_row(0, base);
        row_1 = make_row(1, base);
        row_2 = make_row(2, base);
    endtask

    logic [3:0] pat;
    int exp_col, hs, cyc, lf_count;

    initial begin
        // Reset state
        step(); step();
        reset = 1'b0;
        check("rst_valid", valid_o, 1'b0);
        check("rst_ready", ready_o, 1'b1);
        check("rst_col", col_o, 0);
        check("rst_row", row_o, 0);
        check("rst_ovf", overflow_o, 1'b0);
        check("rst_win", window_o, '0);
        check("rst_lastcol", last_col_o, 1'b0);

        // Single triplet, ready held high
        load(0);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        for (int i = 0; i < 22; i++) begin
            check("t1_valid", valid_o, 1'b1);
            check("t1_col", col_o, i);
            check("t1_row", row_o, 0);
            check("t1_lastcol", last_col_o, (i == 21));
            check("t1_lastframe", last_frame_o, 1'b0);
            if (i == 5) check("t1_tap_r1_dx2", window_o[(5*K+0)*DB +: DB], 39);
            if (i == 0 || i == 13 || i == 21) check("t1_win", window_o, exp_win(0, i));
            step();
        end
        check("t1_end_valid", valid_o, 1'b0);
        check("t1_end_ready", ready_o, 1'b1);

        // Backpressure pattern 1,0,0,1
        pat = 4'b1001;
        load(1);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        exp_col = 0; hs = 0; cyc = 0;
        while (hs < 22 && cyc < 200) begin
            ready_i = pat[cyc % 4];
            #1;
            check("bp_valid", valid_o, 1'b1);
            check("bp_col", col_o, exp_col);
            check("bp_row", row_o, 1);
            check("bp_win", window_o, exp_win(1, exp_col));
            step();
            if (ready_i) begin
                hs++;
                exp_col++;
            end
            cyc++;
        end
        check("bp_handshakes", hs, 22);
        ready_i = 1'b1;
        #1;
        check("bp_end_valid", valid_o, 1'b0);

        // Back-to-back triplet on the final handshake
        load(2);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        for (int i = 0; i < 22; i++) begin
            check("b2b_col", col_o, i);
            if (i == 21) begin
                check("b2b_win21", window_o, exp_win(2, 21));
                load(3);
                valid_i = 1'b1;
                #1;
                check("b2b_ready", ready_o, 1'b1);
            end
            step();
        end
        valid_i = 1'b0;
        check("b2b_valid", valid_o, 1'b1);
        check("b2b_col0", col_o, 0);
        check("b2b_row", row_o, 3);
        check("b2b_win", window_o, exp_win(3, 0));
        check("b2b_ovf", overflow_o, 1'b0);
        for (int i = 0; i < 22; i++) step();
        check("b2b_end_valid", valid_o, 1'b0);

        // Triplet offered mid-sweep is dropped
        load(4);
        valid_i = 1'b1;
        step();
        for (int i = 0; i < 22; i++) begin
            if (i == 10) begin
                load(5);
                valid_i = 1'b1;
                #1;
                check("ovf_ready_busy", ready_o, 1'b0);
            end else begin
                valid_i = 1'b0;
            end
            check("ovf_col", col_o, i);
            check("ovf_win", window_o, exp_win(4, i));
            step();
        end
        valid_i = 1'b0;
        #1;
        check("ovf_flag", overflow_o, 1'b1);
        check("ovf_valid_end", valid_o, 1'b0);
        check("ovf_ready_end", ready_o, 1'b1);
        step();
        check("ovf_sticky", overflow_o, 1'b1);

        // Full frame of back-to-back triplets
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("fr_ovf_clr", overflow_o, 1'b0);
        lf_count = 0;
        load(0);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        for (int k = 0; k < 22; k++) begin
            for (int i = 0; i < 22; i++) begin
                check("fr_col", col_o, i);
                if (i == 0) begin
                    check("fr_row", row_o, k);
                    check("fr_win", window_o, exp_win(k, 0));
                end
                check("fr_lastframe", last_frame_o, (k == 21 && i == 21));
                if (last_frame_o) lf_count++;
                if (i == 21) begin
                    load(k + 1);
                    valid_i = 1'b1;
                end
                step();
                valid_i = 1'b0;
            end
        end
        check("fr_lf_count", lf_count, 1);
        check("fr_wrap_valid", valid_o, 1'b1);
        check("fr_wrap_row", row_o, 0);
        check("fr_wrap_col", col_o, 0);
        check("fr_wrap_win", window_o, exp_win(22, 0));

        // Reset mid-sweep at col 7
        for (int i = 0; i < 7; i++) begin
            valid_i = (i == 3);
            step();
        end
        valid_i = 1'b0;
        check("mr_col7", col_o, 7);
        check("mr_ovf_set", overflow_o, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mr_valid", valid_o, 1'b0);
        check("mr_col", col_o, 0);
        check("mr_row", row_o, 0);
        check("mr_ovf", overflow_o, 1'b0);
        check("mr_ready", ready_o, 1'b1);
        check("mr_win", window_o, '0);
        check("mr_lastcol", last_col_o, 1'b0);
        load(9);
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        check("mr_fresh_valid", valid_o, 1'b1);
        check("mr_fresh_col", col_o, 0);
        check("mr_fresh_row", row_o, 0);
        check("mr_fresh_win", window_o, exp_win(9, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/window_3x3_sweeper.md
Name: window_3x3_sweeper

Overview:
Consumes a row triplet (three full image rows, all K channels) from the upstream 3-line buffer. Sweeps a 3x3 window left to right across it, emitting one window per accepted cycle under a valid/ready handshake. Feeds the downstream 3x3 convolution MAC array. Only "valid" windows are produced (no padding), so each triplet yields W-2 windows and each frame yields H-2 triplets.

Parameters:
DATA_BITS  8   bits per pixel per channel
H          24  image height; triplets per frame = H-2
W          24  image width; windows per triplet = W-2
K          6   channels per pixel

Ports:
clk            in   1                       clock
reset          in   1                       synchronous, active-high reset
row_0          in   W*K*DATA_BITS           oldest (top) row of triplet
row_1          in   W*K*DATA_BITS           middle row
row_2          in   W*K*DATA_BITS           newest (bottom) row
valid_i        in   1                       single-cycle triplet-available pulse; no upstream backpressure
ready_o        out  1                       block can capture a triplet this cycle
window_o       out  9*K*DATA_BITS           current 3x3 window, all channels
valid_o        out  1                       window_o valid
ready_i        in   1                       downstream accepts window
col_o          out  $clog2(W)               window left column, 0..W-3
row_o          out  $clog2(H)               triplet index in frame, 0..H-3
last_col_o     out  1                       valid_o and col_o==W-3
last_frame_o   out  1                       last_col_o and row_o==H-3
overflow_o     out  1                       sticky: triplet dropped while busy

Behaviour:
- Input packing: pixel x, channel c at row bits [(x*K+c)*DATA_BITS +: DATA_BITS].
- Output packing: tap t=r*3+dx (r=0 top, dx=0 left), channel c at window_o bits [(t*K+c)*DATA_BITS +: DATA_BITS]. Tap value = row_r pixel (col_o+dx).
- Rows are copied into local registers on capture. window_o is a combinational column mux of those registers, indexed by col.
- FSM states:
  - IDLE: ready_o=1, valid_o=0. On valid_i: capture rows, col<=0, go to SWEEP.
  - SWEEP: valid_o=1. A handshake (valid_o & ready_i) with col<W-3 does col<=col+1. A handshake at col==W-3 ends the triplet.
- End of triplet:
  - row <= (row==H-3) ? 0 : row+1.
  - If valid_i is asserted in the same cycle: capture the new rows, col<=0, stay in SWEEP (back-to-back, no bubble).
  - Otherwise go to IDLE.
- ready_o = IDLE | (SWEEP & col==W-3 & ready_i). This is combinational from ready_i.
- Latency: valid_i in cycle n gives the first window (col 0) in cycle n+1. With ready_i held at 1, a triplet takes exactly W-2 cycles.
- Backpressure: while valid_o=1 and ready_i=0, window_o, col_o, row_o and last_* hold stable.
- valid_i while ready_o=0: the triplet is ignored, the current sweep is unaffected, and overflow_o<=1. overflow_o stays set until reset.
- Reset, including mid-sweep, takes effect on the next edge:
  - state=IDLE; col=0, row=0, overflow_o=0; row registers zeroed.
  - Outputs after reset: valid_o=0, window_o=0, last_*=0, ready_o=1.
- last_col_o and last_frame_o are combinational from state, col and row. They are gated by valid_o.

Decomposition:
- Shared package (e.g. cnn_pkg):
  - localparams PIX_W=K*DATA_BITS, ROW_W=W*PIX_W, WIN_W=9*PIX_W, COL_BITS, ROW_BITS.
  - State typedef {IDLE, SWEEP}.
  - These are reused by the line buffer and the MAC stage.
- One sub-module, window_col_mux: purely combinational. Three row registers plus col produce window_o, including the packing rule. It is reused later for stride/pad variants.
- The FSM, counters and flags stay in the top module.

Test Plan:
- Reset, then one triplet with pixel value = x + 32*r (channel c adds c), ready_i=1 -> valid_o is high for 22 consecutive cycles. Checks:
  - col_o runs 0..21.
  - Tap (r=1, dx=2), c=0 at col 5 equals 39.
  - last_col_o is high only at col 21.
  - Next cycle valid_o=0, ready_o=1.
- ready_i toggling 1,0,0,1 during a sweep -> window_o, col_o and row_o are held during the stall cycles. Still exactly 22 handshakes, no duplicated or skipped columns.
- Second valid_i on the same edge as the col-21 handshake -> next cycle valid_o=1, col_o=0, window from the new rows, no bubble, overflow_o=0.
- valid_i pulsed at col 10 -> sweep continues with old data through col 21, overflow_o=1 stays set, ready_o=1 afterwards.
- 22 back-to-back triplets -> row_o runs 0..21; last_frame_o pulses once, at row 21 col 21; row_o wraps to 0 on the next triplet.
- reset asserted at col 7 -> next cycle valid_o=0, col_o=0, row_o=0, overflow_o=0. A fresh triplet then starts at col 0.
